baud_rate_en: RTL and testbench
===============================

BAUD_RATE_EN -- requirements
Module: baud_rate_en

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, target serial bit rate in bits/s.
REQ-002 SHALL have parameter FREQUENCY, default 100000000, clk frequency in Hz.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, receive-side ticks per bit.
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 SHALL have port tx_bd_en, output, 1 bit, one-cycle transmit bit-rate enable pulse.
REQ-007 SHALL have port rx_bd_en, output, 1 bit, one-cycle receive oversample enable pulse.

Function
REQ-008 SHALL define DIV_TX = round(FREQUENCY/BAUD_RATE) and DIV_RX = round(FREQUENCY/(BAUD_RATE*OVERSAMPLE)), computed at elaboration; ties round up.
REQ-009 SHALL stop elaboration with an error if DIV_RX < 2, or if any parameter is 0.
REQ-010 SHALL, in integer mode, run an independent free-running counter per output: 0 to DIV-1, then wrap to 0.
REQ-011 SHALL assert each output, registered, high for exactly one clk cycle per wrap, and low otherwise.
REQ-012 SHALL produce the first tx_bd_en pulse in the cycle after the DIV_TX-th rising edge following rst deassertion; rx_bd_en likewise with DIV_RX; period thereafter exactly DIV.
REQ-013 SHALL keep tx and rx generators independent: simultaneous pulses are legal; neither counter resets the other.
REQ-014 SHALL size counters to ceil(log2(DIV)) bits minimum, with no overflow at any legal parameter set.

Reset
REQ-015 SHALL, while rst is high at a clk edge, clear all counters and accumulators to 0 and drive tx_bd_en=0 and rx_bd_en=0.
REQ-016 SHALL treat rst asserted mid-period as a restart: no pulse during reset; timing per REQ-012 from release.

Configuration
REQ-017 SHALL honour macro BAUD_FRAC_ACC_EN. When defined, each generator is a phase accumulator: each cycle acc += STEP (STEP = BAUD_RATE for tx, BAUD_RATE*OVERSAMPLE for rx). When acc+STEP >= FREQUENCY, the generator pulses and acc becomes acc+STEP-FREQUENCY. This gives an exact long-term average rate with pulse spacing floor or ceil of FREQUENCY/STEP. When not defined, integer mode per REQ-010 to REQ-012 applies.
REQ-018 SHALL size the accumulator to hold FREQUENCY+STEP without overflow; the reset value is 0.

Structure
REQ-019 SHALL place the divisor-rounding function, width helper (clog2) and the default OVERSAMPLE constant in shared package baud_rate_pkg.
REQ-020 SHALL implement one sub-module, baud_tick_gen, with parameters DIV or STEP/FREQUENCY; it is instantiated twice (tx and rx).

Verification
REQ-021 Default parameters, integer mode, rst high 5 cycles then low: tx_bd_en pulses every 868 cycles, first pulse 868 cycles after release; rx_bd_en pulses every 54 cycles.
REQ-022 FREQUENCY=1000, BAUD_RATE=10, OVERSAMPLE=16, integer mode: tx period 100 cycles, rx period 6 cycles; each pulse is exactly 1 cycle wide.
REQ-023 Same parameters, with BAUD_FRAC_ACC_EN: exactly 10 tx pulses and 160 rx pulses per 1000 cycles; rx spacing is only 6 or 7 cycles.
REQ-024 Default parameters, rst reasserted 400 cycles after release for 3 cycles: outputs 0 during reset; next tx pulse 868 cycles after the second release.
REQ-025 While rst is held high for 2000 cycles: tx_bd_en and rx_bd_en remain 0 throughout.
REQ-026 FREQUENCY=100, BAUD_RATE=10, OVERSAMPLE=16 (DIV_RX<2): elaboration fails with an error.

Source files
------------

// File: rtl/baud_rate_pkg.sv
// baud_rate_pkg: shared helpers for the baud-rate enable generator.
//   OVERSAMPLE_DEFAULT : default receive oversampling factor
//   clog2()            : bits needed to hold values 0..v-1 (minimum 1)
//   div_round()        : integer divide rounded to nearest, ties rounding up
package baud_rate_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     w;
    longint unsigned x;
    w = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // round(num/den) with ties up == floor((2*num + den) / (2*den))
  function automatic longint unsigned div_round(input longint unsigned num,
                                                input longint unsigned den);
    if (den == 0) return 0;
    return (2 * num + den) / (2 * den);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: single free-running enable-pulse generator.
//   Macro BAUD_FRAC_ACC_EN selects a phase accumulator (params STEP, FREQUENCY);
//   otherwise an integer divider (param DIV) is built.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   o_tick : registered one-cycle enable pulse
module baud_tick_gen
  import baud_rate_pkg::*;
#(
`ifdef BAUD_FRAC_ACC_EN
  parameter int unsigned STEP      = 1,
  parameter int unsigned FREQUENCY = 2
`else
  parameter int unsigned DIV       = 2
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  logic r_tick;

`ifdef BAUD_FRAC_ACC_EN
  // Accumulator stays below FREQUENCY, so acc+STEP never exceeds FREQUENCY+STEP.
  localparam int unsigned AW = clog2(64'(FREQUENCY) + 64'(STEP) + 64'd1);
  localparam logic [AW-1:0] A_STEP = AW'(STEP);
  localparam logic [AW-1:0] A_FREQ = AW'(FREQUENCY);

  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_sum;

  always_comb begin
    w_sum = r_acc + A_STEP;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_sum >= A_FREQ) begin
      r_acc  <= w_sum - A_FREQ;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_tick <= 1'b0;
    end
  end
`else
  localparam int unsigned     CW   = clog2(64'(DIV));
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end
`endif

  assign o_tick = r_tick;

endmodule

// File: rtl/baud_rate_en.sv
// baud_rate_en: transmit bit-rate and receive oversample enable generator.
//   Macro BAUD_FRAC_ACC_EN: when defined, both generators are exact-average
//   phase accumulators; otherwise rounded integer dividers.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   tx_bd_en : one-cycle pulse at BAUD_RATE
//   rx_bd_en : one-cycle pulse at BAUD_RATE*OVERSAMPLE
module baud_rate_en
  import baud_rate_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FREQUENCY  = 100000000,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tx_bd_en,
  output logic rx_bd_en
);

  localparam longint unsigned DIV_RX =
    div_round(64'(FREQUENCY), 64'(BAUD_RATE) * 64'(OVERSAMPLE));

  if (BAUD_RATE == 0 || FREQUENCY == 0 || OVERSAMPLE == 0) begin : g_bad_param
    $error("baud_rate_en: BAUD_RATE, FREQUENCY and OVERSAMPLE must be non-zero");
  end else if (DIV_RX < 2) begin : g_bad_div
    $error("baud_rate_en: receive divisor below 2 (FREQUENCY too low for BAUD_RATE*OVERSAMPLE)");
  end

`ifdef BAUD_FRAC_ACC_EN
  localparam longint unsigned STEP_TX = 64'(BAUD_RATE);
  localparam longint unsigned STEP_RX = 64'(BAUD_RATE) * 64'(OVERSAMPLE);

  baud_tick_gen #(.STEP(32'(STEP_TX)), .FREQUENCY(FREQUENCY)) u_tx_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (tx_bd_en)
  );

  baud_tick_gen #(.STEP(32'(STEP_RX)), .FREQUENCY(FREQUENCY)) u_rx_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (rx_bd_en)
  );
`else
  localparam longint unsigned DIV_TX = div_round(64'(FREQUENCY), 64'(BAUD_RATE));

  baud_tick_gen #(.DIV(32'(DIV_TX))) u_tx_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (tx_bd_en)
  );

  baud_tick_gen #(.DIV(32'(DIV_RX))) u_rx_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (rx_bd_en)
  );
`endif

endmodule

// File: tb/tb_baud_rate_en.sv
// tb_baud_rate_en: checks two configurations side by side (default and
// FREQUENCY=1000/BAUD_RATE=10/OVERSAMPLE=16). Expected pulse cycles are
// derived in closed form and queued at each reset release.
module tb_baud_rate_en;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic def_tx, def_rx, sm_tx, sm_rx;

  always #5 clk = ~clk;

  baud_rate_en #(.BAUD_RATE(115200), .FREQUENCY(100000000), .OVERSAMPLE(16)) u_dut_def (
    .clk      (clk),
    .rst      (rst),
    .tx_bd_en (def_tx),
    .rx_bd_en (def_rx)
  );

  baud_rate_en #(.BAUD_RATE(10), .FREQUENCY(1000), .OVERSAMPLE(16)) u_dut_small (
    .clk      (clk),
    .rst      (rst),
    .tx_bd_en (sm_tx),
    .rx_bd_en (sm_rx)
  );

  // Index 0: default tx, 1: default rx, 2: small tx, 3: small rx
  function automatic longint unsigned div_of(input int idx);
    case (idx)
      0:       return 868;
      1:       return 54;
      2:       return 100;
      default: return 6;
    endcase
  endfunction

  function automatic longint unsigned step_of(input int idx);
    case (idx)
      0:       return 115200;
      1:       return 1843200;
      2:       return 10;
      default: return 160;
    endcase
  endfunction

  function automatic longint unsigned freq_of(input int idx);
    return (idx < 2) ? 64'd100000000 : 64'd1000;
  endfunction

  // Does generator idx pulse on the e-th rising edge after release?
  function automatic bit fires(input int idx, input longint unsigned e);
`ifdef BAUD_FRAC_ACC_EN
    return ((e * step_of(idx)) / freq_of(idx)) != (((e - 1) * step_of(idx)) / freq_of(idx));
`else
    return (e % div_of(idx)) == 0;
`endif
  endfunction

  // Pulses expected within the first h edges after release.
  function automatic int n_expected(input int idx, input longint unsigned h);
`ifdef BAUD_FRAC_ACC_EN
    return int'((h * step_of(idx)) / freq_of(idx));
`else
    return int'(h / div_of(idx));
`endif
  endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned exp_q[4][$];
  int          pulse_cnt[4] = '{0, 0, 0, 0};
  int          snap[4];
  int          n_assert = 0;
  int          n_fail   = 0;
  string       names[4] = '{"def_tx", "def_rx", "small_tx", "small_rx"};
  logic        mon_obs[4];
  logic        mon_exp;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare whenever a pulse is expected or one is seen.
  always @(negedge clk) begin
    mon_obs[0] = def_tx;
    mon_obs[1] = def_rx;
    mon_obs[2] = sm_tx;
    mon_obs[3] = sm_rx;
    for (int i = 0; i < 4; i++) begin
      mon_exp = 1'b0;
      if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
        mon_exp = 1'b1;
        void'(exp_q[i].pop_front());
      end
      if (mon_obs[i] === 1'b1) pulse_cnt[i]++;
      if (mon_obs[i] !== 1'b0 || mon_exp) check({"sb_", names[i]}, mon_obs[i], mon_exp);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic release_rst(input int unsigned h);
    int unsigned base;
    base = cyc;
    rst  = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int unsigned e = 1; e <= h; e++)
        if (fires(i, longint'(e))) exp_q[i].push_back(base + e);
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4; i++) snap[i] = pulse_cnt[i];
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) step();
    check("reset_def_tx", def_tx, 1'b0);
    check("reset_def_rx", def_rx, 1'b0);
    check("reset_small_tx", sm_tx, 1'b0);
    check("reset_small_rx", sm_rx, 1'b0);

    // Release, then restart mid-period 400 cycles later for 3 cycles.
    release_rst(400);
    repeat (400) step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_def_tx", def_tx, 1'b0);
      check("midrst_def_rx", def_rx, 1'b0);
      check("midrst_small_tx", sm_tx, 1'b0);
      check("midrst_small_rx", sm_rx, 1'b0);
    end

    // Second release: timing restarts from here.
    take_snap();
    release_rst(2000);
    repeat (2000) step();
    for (int i = 0; i < 4; i++)
      check_cnt({"cnt2000_", names[i]}, pulse_cnt[i] - snap[i], n_expected(i, 2000));

    // Long reset hold: no pulses at all.
    rst = 1'b1;
    take_snap();
    repeat (2000) step();
    for (int i = 0; i < 4; i++)
      check_cnt({"hold_", names[i]}, pulse_cnt[i] - snap[i], 0);

    // 1000-cycle window for rate counts.
    take_snap();
    release_rst(1000);
    repeat (1000) step();
    for (int i = 0; i < 4; i++)
      check_cnt({"cnt1000_", names[i]}, pulse_cnt[i] - snap[i], n_expected(i, 1000));
`ifdef BAUD_FRAC_ACC_EN
    check_cnt("rate_small_tx", pulse_cnt[2] - snap[2], 10);
    check_cnt("rate_small_rx", pulse_cnt[3] - snap[3], 160);
`else
    check_cnt("rate_small_tx", pulse_cnt[2] - snap[2], 10);
    check_cnt("rate_small_rx", pulse_cnt[3] - snap[3], 166);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
